btn_conditioner_array: RTL and testbench



---
 rtl/btn_pkg.sv | 31 +++
 rtl/btn_conditioner_array_if.sv | 42 ++++
 rtl/btn_chan.sv | 147 ++++++++++++++
 rtl/btn_conditioner_array.sv | 46 ++++
 tb/tb_btn_conditioner_array.sv | 106 ++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the conditioner has no flow control, every input is sampled each cycle.
//
// Contents:
//   btn_state_e          per-channel debounce state; bit 1 doubles as the debounced level
//   N_CH_DEF             default number of button channels
//   DB_W_DEF             default debounce window exponent (2^DB_W cycles)
//   REP_W_DEF            default repeat counter width (first repeat after 2^REP_W cycles)
//   rpt_reload_top2      top two bits of the repeat-counter reload value
package btn_pkg;

  // Encoding is chosen so that state[1] is high exactly in the "button is down"
  // half of the machine (HELD, RELEASE_WAIT). The debounced level is taken
  // straight from that flop bit.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b11,
    RELEASE_WAIT = 2'b10
  } btn_state_e;

  localparam int unsigned N_CH_DEF  = 5;
  localparam int unsigned DB_W_DEF  = 20;
  localparam int unsigned REP_W_DEF = 25;

  // Reloading to 3*2^(REP_W-2) ('b11 followed by zeros) leaves exactly
  // 2^(REP_W-2) counts to all-ones, which sets the steady repeat period.
  localparam logic [1:0] rpt_reload_top2 = 2'b11;

endpackage

// File: rtl/btn_conditioner_array_if.sv
// Button bundle between the pad ring and the conditioner array.
// Latency: n/a (wires only).
// Backpressure: none; outputs are level/pulse signals consumed every cycle.
//
// Signals (all N_CH wide, one bit per channel):
//   PB    raw asynchronous button pads        (pad side -> conditioner)
//   DPB   debounced level                     (conditioner -> consumers)
//   SCEN  one-cycle pulse per accepted press  (conditioner -> consumers)
//   RPT   one-cycle hold-to-repeat pulses     (conditioner -> consumers)
//   EVT   SCEN | RPT step event               (conditioner -> consumers)
// Modports:
//   master  pad/consumer side: drives PB, observes the conditioned outputs
//   slave   conditioner side: reads PB, drives the conditioned outputs
interface btn_conditioner_array_if
  import btn_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
);

  logic [N_CH-1:0] PB;
  logic [N_CH-1:0] DPB;
  logic [N_CH-1:0] SCEN;
  logic [N_CH-1:0] RPT;
  logic [N_CH-1:0] EVT;

  modport master (
    output PB,
    input  DPB,
    input  SCEN,
    input  RPT,
    input  EVT
  );

  modport slave (
    input  PB,
    output DPB,
    output SCEN,
    output RPT,
    output EVT
  );

endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, counter-based debounce FSM, optional hold-to-repeat.
// Latency: DPB/SCEN rise after edge 2^DB_W+3 of a stable press; DPB falls after edge 2^DB_W+3 of stable release.
// Backpressure: none; the raw pad is sampled every cycle and pulses are never held off.
//
// Ports:
//   CLK    system clock
//   RESET  synchronous active-high reset; clears synchroniser, counters and FSM
//   pb     raw asynchronous pad
//   dpb    debounced level (registered)
//   scen   one-cycle pulse on an accepted press (registered)
//   rpt    one-cycle auto-repeat pulse while held (registered, 0 unless BTN_AUTOREPEAT_EN)
// Build option: define BTN_AUTOREPEAT_EN to build the repeat counter; otherwise rpt is tied low.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DB_W  = DB_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pb,
  output logic dpb,
  output logic scen,
  output logic rpt
);

  localparam logic [DB_W-1:0] DB_MAX = '1;

  // Synchroniser; s is the only version of the pad the FSM ever looks at.
  logic sync_q;
  logic s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_q <= pb;
      s      <= sync_q;
    end
  end

  btn_state_e      state, state_nxt;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;
  logic            scen_nxt;
  logic            rpt_clr;   // entering HELD: restart the repeat timing
  logic            rpt_run;   // HELD with the button still down: repeat counter advances

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      db_cnt <= '0;
      scen   <= 1'b0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
      scen   <= scen_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    scen_nxt   = 1'b0;
    rpt_clr    = 1'b0;
    rpt_run    = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          // Too short to be a press.
          state_nxt = IDLE;
        end else if (db_cnt == DB_MAX) begin
          state_nxt = HELD;
          scen_nxt  = 1'b1;
          rpt_clr   = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt  = RELEASE_WAIT;
          db_cnt_nxt = '0;
        end else begin
          rpt_run = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          // Release bounce: resume the hold with the repeat timing intact,
          // and without a second press pulse.
          state_nxt = HELD;
        end else if (db_cnt == DB_MAX) begin
          state_nxt = IDLE;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // HELD and RELEASE_WAIT both have bit 1 set, so the level is a flop output.
  assign dpb = state[1];

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [REP_W-1:0] RPT_MAX    = '1;
  localparam logic [REP_W-1:0] RPT_RELOAD = {rpt_reload_top2, {(REP_W-2){1'b0}}};

  logic [REP_W-1:0] rpt_cnt;

  // Counter is frozen outside HELD (including RELEASE_WAIT), so a release
  // bounce neither restarts nor advances the repeat timing.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rpt_cnt <= '0;
      rpt     <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (rpt_clr) begin
        rpt_cnt <= '0;
      end else if (rpt_run) begin
        if (rpt_cnt == RPT_MAX) begin
          rpt     <= 1'b1;
          rpt_cnt <= RPT_RELOAD;
        end else begin
          rpt_cnt <= rpt_cnt + REP_W'(1);
        end
      end
    end
  end
`else
  // Repeat disabled: the FSM hooks stay in place but drive nothing.
  logic unused_rpt_hooks;
  assign unused_rpt_hooks = rpt_clr ^ rpt_run;
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner_array.sv
// N-channel push-button conditioner: per-channel synchronise, debounce, press pulse and hold-to-repeat.
// Latency: press/release recognised 2^DB_W+3 edges after the pad settles; EVT is combinational from registered SCEN/RPT.
// Backpressure: none; channels are independent and pulses are produced unconditionally.
//
// Ports:
//   CLK    system clock
//   RESET  synchronous active-high reset, clears every channel
//   btn    slave side of btn_conditioner_array_if (PB in; DPB, SCEN, RPT, EVT out)
// Build option: BTN_AUTOREPEAT_EN enables the auto-repeat pulses; without it RPT=0 and EVT=SCEN.
module btn_conditioner_array
  import btn_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DB_W  = DB_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  btn_conditioner_array_if.slave btn
);

  logic [N_CH-1:0] dpb_v;
  logic [N_CH-1:0] scen_v;
  logic [N_CH-1:0] rpt_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_chan #(
      .DB_W  (DB_W),
      .REP_W (REP_W)
    ) u_chan (
      .CLK   (CLK),
      .RESET (RESET),
      .pb    (btn.PB[i]),
      .dpb   (dpb_v[i]),
      .scen  (scen_v[i]),
      .rpt   (rpt_v[i])
    );
  end

  assign btn.DPB  = dpb_v;
  assign btn.SCEN = scen_v;
  assign btn.RPT  = rpt_v;
  // SCEN and RPT are mutually exclusive per channel, so the OR is a clean step stream.
  assign btn.EVT  = scen_v | rpt_v;

endmodule

// File: tb/tb_btn_conditioner_array.sv
// Directed bench for btn_conditioner_array with N_CH=5, DB_W=3, REP_W=5.
// Edge e of each scenario is the first posedge that samples the scenario's PB value for that step.
// Outputs are sampled 1 time unit after each posedge.
module tb_btn_conditioner_array;

  localparam int N_CH  = 5;
  localparam int DB_W  = 3;
  localparam int REP_W = 5;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  btn_conditioner_array_if #(.N_CH(N_CH)) btn ();

  btn_conditioner_array #(
    .N_CH  (N_CH),
    .DB_W  (DB_W),
    .REP_W (REP_W)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .btn   (btn)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-hot channel mask when c holds, else zero.
  function automatic logic [4:0] on(input bit c, input int ch);
    logic [4:0] m;
    m = '0;
    if (c) m[ch] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs, clock it, then check every output vector.
  task automatic step(input string scn, input int e, input logic rst, input logic [4:0] pb,
                      input logic [4:0] e_dpb, input logic [4:0] e_scen, input logic [4:0] e_rpt);
    logic [4:0] x_rpt;
    x_rpt = e_rpt;
`ifndef BTN_AUTOREPEAT_EN
    x_rpt = '0;
`endif
    @(negedge CLK);
    RESET  = rst;
    btn.PB = pb;
    @(posedge CLK);
    #1;
    chk($sformatf("%s e%0d DPB", scn, e),  32'(btn.DPB),  32'(e_dpb));
    chk($sformatf("%s e%0d SCEN", scn, e), 32'(btn.SCEN), 32'(e_scen));
    chk($sformatf("%s e%0d RPT", scn, e),  32'(btn.RPT),  32'(x_rpt));
    chk($sformatf("%s e%0d EVT", scn, e),  32'(btn.EVT),  32'(e_scen | x_rpt));
  endtask

  initial begin
    RESET  = 1'b1;
    btn.PB = '0;

    // Reset state.
    for (int e = 1; e <= 3; e++) step("reset", e, 1'b1, 5'b0, 5'b0, 5'b0, 5'b0);

    // Clean press on ch0: high for edges 1..20, press seen at 11, release seen at 31.
    for (int e = 1; e <= 34; e++)
      step("press", e, 1'b0, on(e <= 20, 0), on(e >= 11 && e <= 30, 0), on(e == 11, 0), 5'b0);

    // Glitch on ch1: 6 cycles high never reaches the end of the window.
    for (int e = 1; e <= 15; e++)
      step("glitch", e, 1'b0, on(e <= 6, 1), 5'b0, 5'b0, 5'b0);

    // Auto-repeat on ch2: first repeat 32 after SCEN, then every 8.
    for (int e = 1; e <= 84; e++)
      step("repeat", e, 1'b0, on(e <= 70, 2), on(e >= 11 && e <= 80, 2), on(e == 11, 2),
           on(e == 43 || e == 51 || e == 59 || e == 67, 2));

    // Release bounce on ch3: low 4, high 2, then low; level holds, single press pulse.
    for (int e = 1; e <= 40; e++)
      step("bounce", e, 1'b0, on(e <= 20 || (e >= 25 && e <= 26), 3),
           on(e >= 11 && e <= 36, 3), on(e == 11, 3), 5'b0);

    // Simultaneous press on ch0 and ch4.
    for (int e = 1; e <= 28; e++)
      step("simul", e, 1'b0, on(e <= 15, 0) | on(e <= 15, 4),
           on(e >= 11 && e <= 25, 0) | on(e >= 11 && e <= 25, 4),
           on(e == 11, 0) | on(e == 11, 4), 5'b0);

    // Reset for one cycle at edge 20 while ch2 is held; full re-debounce from edge 21.
    for (int e = 1; e <= 50; e++)
      step("rsthold", e, logic'(e == 20), on(e <= 35, 2),
           on((e >= 11 && e <= 19) || (e >= 31 && e <= 45), 2),
           on(e == 11 || e == 31, 2), 5'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
